// File: rtl/mul_seq_ctrl_pkg.sv
// mul_seq_ctrl_pkg: shared widths, flag indices and controller states
package mul_seq_ctrl_pkg;
    localparam int WORD_W = 64;
    localparam int CC_ZF  = 0;
    localparam int CC_SF  = 1;
    localparam int CC_OF  = 2;
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/mul_acc_step.sv
// mul_acc_step: ripple of 1-bit full adders, 64+64 -> 65-bit sum with carry-out
module mul_acc_step
    import mul_seq_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    output logic [WORD_W:0]   sum
);
    logic c;
    // full-adder chain, carry passed bit to bit
    always_comb begin
        c = 1'b0;
        sum = '0;
        for (int i = 0; i < WORD_W; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        sum[WORD_W] = c;
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative signed 64x64 shift-add multiplier with handshakes and flags
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int ITERS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] out,
    output logic [2:0]        cf_mul
);
    localparam int CW = $clog2(ITERS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] mcand, mplier, acc_hi;
    logic              neg;
    logic [WORD_W-1:0] a_abs, b_abs, addend, fix_out;
    logic [WORD_W:0]   step_sum;
    logic [2:0]        fix_cf;

    assign a_abs  = a[WORD_W-1] ? -a : a;
    assign b_abs  = b[WORD_W-1] ? -b : b;
    assign addend = mplier[0] ? mcand : '0;

    mul_acc_step u_step (
        .x   (acc_hi),
        .y   (addend),
        .sum (step_sum)
    );

    // sign fix and flags from the 128-bit magnitude {acc_hi, mplier}
    always_comb begin
        fix_out = neg ? -mplier : mplier;
        fix_cf = '0;
        fix_cf[CC_ZF] = (fix_out == '0);
        fix_cf[CC_SF] = fix_out[WORD_W-1];
        fix_cf[CC_OF] = (|acc_hi) || (neg ? (mplier[WORD_W-1] && |mplier[WORD_W-2:0]) : mplier[WORD_W-1]);
    end

    // controller FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc_hi    <= '0;
            neg       <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            out       <= '0;
            cf_mul    <= '0;
        end else if (abort) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    mcand     <= a_abs;
                    mplier    <= b_abs;
                    neg       <= a[WORD_W-1] ^ b[WORD_W-1];
                    acc_hi    <= '0;
                    cnt       <= '0;
                    req_ready <= 1'b0;
                    state     <= ITER;
                end
                ITER: begin
                    acc_hi <= step_sum[WORD_W:1];
                    mplier <= {step_sum[0], mplier[WORD_W-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CNT_LAST) state <= FIX;
                end
                FIX: begin
                    out       <= fix_out;
                    cf_mul    <= fix_cf;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed vectors with hand-computed products and flags
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        abort = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] res;
    logic [2:0]  cf_mul;
    int          n_cmp = 0;
    int          n_err = 0;

    mul_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .out       (res),
        .cf_mul    (cf_mul)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] va, input logic [63:0] vb);
        int w = 0;
        while (!req_ready && w < 200) begin
            tick(1);
            w++;
        end
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        a = va;
        b = vb;
        req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk("req_ready_after_accept", 64'(req_ready), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                          input logic [63:0] exp_out, input logic [2:0] exp_cf, input int hold);
        int lat = 0;
        accept(va, vb);
        rsp_ready = 1'b1;
        do begin
            tick(1);
            lat++;
        end while (!rsp_valid && lat < 200);
        rsp_ready = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'd65);
        chk({tag, "_out"}, res, exp_out);
        chk({tag, "_cf"}, 64'(cf_mul), 64'(exp_cf));
        for (int i = 0; i < hold; i++) begin
            tick(1);
            chk({tag, "_hold_out"}, res, exp_out);
            chk({tag, "_hold_cf"}, 64'(cf_mul), 64'(exp_cf));
            chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
            chk({tag, "_hold_rsp_valid"}, 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_req_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int seen;
        #12;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_out", res, 64'd0);
        chk("reset_cf", 64'(cf_mul), 64'd0);
        rst_n = 1'b1;
        tick(2);

        run_op("3x-5", 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 3'b010, 0);
        run_op("0x1234", 64'd0, 64'h1234, 64'd0, 3'b001, 0);
        run_op("2p32x2p31", 64'h1_0000_0000, 64'h8000_0000, 64'h8000_0000_0000_0000, 3'b110, 0);
        run_op("m2p32x2p31", -64'sh1_0000_0000, 64'h8000_0000, 64'h8000_0000_0000_0000, 3'b010, 0);
        run_op("minxm1", 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 3'b110, 0);
        run_op("m7xm6_hold", -64'sd7, -64'sd6, 64'd42, 3'b000, 10);

        accept(64'd9, 64'd9);
        tick(30);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (rsp_valid) seen++;
        end
        chk("abort_no_response", 64'(seen), 64'd0);
        chk("abort_out_kept", res, 64'd42);
        run_op("7x6", 64'd7, 64'd6, 64'd42, 3'b000, 0);

        run_op("m1x1", -64'sd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 0);
        accept(64'd5, 64'd5);
        tick(20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req_ready", 64'(req_ready), 64'd1);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_out", res, 64'd0);
        chk("async_rst_cf", 64'(cf_mul), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick(1);
            if (rsp_valid) seen++;
        end
        chk("rst_no_response", 64'(seen), 64'd0);
        run_op("5x5", 64'd5, 64'd5, 64'd25, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
